// File: rtl/mc_control_fsm.sv
// +----------------------------------------------------------------------------+
// | Module      : mc_control_fsm                                               |
// | Description : Multi-cycle sequencer for a 32-bit MIPS-subset CPU sharing a |
// |               single variable-latency memory port for instructions and     |
// |               data. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB|
// |               and drives datapath selects, write enables, ALUControl and   |
// |               the req/ready memory handshake.                              |
// | Parameters  : MEM_WAIT_MAX - not-ready cycles tolerated per memory access  |
// |               before a bus-timeout halt (0 disables the timeout).          |
// | Config macro: ILLEGAL_TRAP_EN - when defined an unknown opcode halts with  |
// |               exc_code=10; otherwise it retires as a one-cycle no-op.      |
// | Ports       : CLK, reset (sync, active-high); Op/Funct from IR; Zero from  |
// |               the ALU; mem_ready/mem_req/mem_we handshake; IorD, IRWrite,  |
// |               PCEn, TargetWr, RegDst, RegWrite, MemOrReg, PCSrc, ALUSrcA,  |
// |               ALUSrcB, ALUControl datapath controls; retire, halted,       |
// |               exc_code status.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module mc_control_fsm #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCEn,
    output logic        TargetWr,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        MemOrReg,
    output logic [1:0]  PCSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [10:0] ALUControl,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  exc_code
);

    localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    localparam logic [5:0]  C_OP_RTYPE = 6'h00;
    localparam logic [5:0]  C_OP_ORI   = 6'h0D;
    localparam logic [5:0]  C_OP_LW    = 6'h23;
    localparam logic [5:0]  C_OP_SW    = 6'h2B;
    localparam logic [5:0]  C_OP_BEQ   = 6'h04;
    localparam logic [5:0]  C_OP_J     = 6'h02;
    localparam logic [10:0] C_ALU_ADDU = 11'h021;
    localparam logic [10:0] C_ALU_SUBU = 11'h023;
    localparam logic [10:0] C_ALU_OR   = 11'h025;
    localparam logic [1:0]  C_EXC_BUS  = 2'b01;
    localparam logic [1:0]  C_EXC_ILL  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_EXEC_I  = 4'd3,
        S_WB_R    = 4'd4,
        S_ADDR    = 4'd5,
        S_MEM_RD  = 4'd6,
        S_MEM_WR  = 4'd7,
        S_WB_MEM  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ILLEGAL = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_wait_cnt;
    logic [1:0]     r_exc;
    logic           r_rtype;   // instruction in flight is R-type (selects rd in WB_R)
    logic           r_load;    // instruction in flight is lw (ADDR -> MEM_RD)
    logic           w_mem_state;
    logic           w_timeout;
    logic           w_shift;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_timeout   = (MEM_WAIT_MAX != 0) && w_mem_state && !mem_ready
                         && (r_wait_cnt == CW'(MEM_WAIT_MAX));
    // sll/srl/sra take the shift amount from the instruction, not from rs
    assign w_shift     = (Funct == 6'h00) || (Funct == 6'h02) || (Funct == 6'h03);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_exc      <= 2'b00;
            r_rtype    <= 1'b0;
            r_load     <= 1'b0;
        end else begin
            // Wait counter only moves in memory states; leaving one always clears it,
            // so every access starts counting from zero.
            if (w_mem_state) begin
                if (mem_ready) begin
                    r_wait_cnt <= '0;
                end else if (w_timeout) begin
                    r_wait_cnt <= '0;
                    r_state    <= S_HALT;
                    r_exc      <= C_EXC_BUS;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end

            case (r_state)
                S_FETCH:  if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_rtype <= (Op == C_OP_RTYPE);
                    r_load  <= (Op == C_OP_LW);
                    case (Op)
                        C_OP_RTYPE:      r_state <= S_EXEC_R;
                        C_OP_ORI:        r_state <= S_EXEC_I;
                        C_OP_LW, C_OP_SW: r_state <= S_ADDR;
                        C_OP_BEQ:        r_state <= S_BRANCH;
                        C_OP_J:          r_state <= S_JUMP;
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            r_state <= S_HALT;
                            r_exc   <= C_EXC_ILL;
`else
                            r_state <= S_ILLEGAL;
`endif
                        end
                    endcase
                end
                S_EXEC_R, S_EXEC_I: r_state <= S_WB_R;
                S_ADDR:   r_state <= r_load ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: if (mem_ready) r_state <= S_WB_MEM;
                S_MEM_WR: if (mem_ready) r_state <= S_FETCH;
                S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP, S_ILLEGAL: r_state <= S_FETCH;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Output decode; reset masks everything in the same cycle so an in-flight
    // access or write is abandoned immediately.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCEn       = 1'b0;
        TargetWr   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        MemOrReg   = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 11'h000;
        retire     = 1'b0;
        halted     = 1'b0;
        exc_code   = 2'b00;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    ALUSrcB    = 2'b01;
                    ALUControl = C_ALU_ADDU;
                    IRWrite    = mem_ready;
                    PCEn       = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    ALUControl = C_ALU_ADDU;
                    TargetWr   = 1'b1;
                end
                S_EXEC_R: begin
                    ALUSrcA    = w_shift ? 2'b10 : 2'b01;
                    ALUControl = {5'b0, Funct};
                    TargetWr   = 1'b1;
                end
                S_EXEC_I: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b10;
                    ALUControl = C_ALU_OR;
                    TargetWr   = 1'b1;
                end
                S_WB_R: begin
                    RegWrite = 1'b1;
                    RegDst   = r_rtype;
                    retire   = 1'b1;
                end
                S_ADDR: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b10;
                    ALUControl = C_ALU_ADDU;
                    TargetWr   = 1'b1;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    IorD    = 1'b1;
                    retire  = mem_ready;
                end
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    MemOrReg = 1'b1;
                    retire   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = 2'b01;
                    ALUControl = C_ALU_SUBU;
                    PCSrc      = 2'b01;
                    PCEn       = Zero;
                    retire     = 1'b1;
                end
                S_JUMP: begin
                    PCSrc  = 2'b10;
                    PCEn   = 1'b1;
                    retire = 1'b1;
                end
                S_ILLEGAL: retire = 1'b1;
                S_HALT: begin
                    halted   = 1'b1;
                    exc_code = r_exc;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_mc_control_fsm                                            |
// | Description : Self-checking bench for mc_control_fsm. Instructions are     |
// |               expanded into the list of phases they must walk through      |
// |               (with the chosen memory wait cycles), each phase maps to the |
// |               output table of the sequencer, and a compare process checks  |
// |               every cycle. Directed cases pin cycle counts and key values. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mc_control_fsm;

    localparam int WMAX = 4;

    localparam logic [5:0] C_OP_R   = 6'h00;
    localparam logic [5:0] C_OP_ORI = 6'h0D;
    localparam logic [5:0] C_OP_LW  = 6'h23;
    localparam logic [5:0] C_OP_SW  = 6'h2B;
    localparam logic [5:0] C_OP_BEQ = 6'h04;
    localparam logic [5:0] C_OP_J   = 6'h02;

    localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC_R = 2, P_EXEC_I = 3, P_WB_R = 4,
                   P_ADDR = 5, P_MEM_RD = 6, P_MEM_WR = 7, P_WB_MEM = 8, P_BRANCH = 9,
                   P_JUMP = 10, P_ILLEGAL = 11, P_HALT = 12, P_RESET = 13;

    typedef struct packed {
        logic        mem_req, mem_we, IorD, IRWrite, PCEn, TargetWr, RegDst, RegWrite, MemOrReg;
        logic [1:0]  PCSrc, ALUSrcA, ALUSrcB;
        logic [10:0] ALUControl;
        logic        retire, halted;
        logic [1:0]  exc_code;
    } out_t;

    typedef struct {
        int         ph;
        bit         rdy;
        bit         zero;
        logic [5:0] op;
        logic [5:0] fn;
        logic [1:0] exc;
    } step_t;

    logic        CLK = 1'b0;
    logic        reset, Zero, mem_ready;
    logic [5:0]  Op, Funct;
    logic        mem_req, mem_we, IorD, IRWrite, PCEn, TargetWr, RegDst, RegWrite, MemOrReg;
    logic [1:0]  PCSrc, ALUSrcA, ALUSrcB, exc_code;
    logic [10:0] ALUControl;
    logic        retire, halted;

    always #5 CLK = ~CLK;

    mc_control_fsm #(.MEM_WAIT_MAX(WMAX)) dut (
        .CLK(CLK), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWrite(IRWrite), .PCEn(PCEn),
        .TargetWr(TargetWr), .RegDst(RegDst), .RegWrite(RegWrite), .MemOrReg(MemOrReg),
        .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .retire(retire), .halted(halted), .exc_code(exc_code)
    );

    out_t act;
    assign act = {mem_req, mem_we, IorD, IRWrite, PCEn, TargetWr, RegDst, RegWrite, MemOrReg,
                  PCSrc, ALUSrcA, ALUSrcB, ALUControl, retire, halted, exc_code};

    step_t      seq[$];
    out_t       exp_o;
    int         exp_ph;
    bit         chk_pend;
    int         n_tests, n_fail;
    int         n_cyc, n_retire, n_memreq, n_memreq_iord, n_pcen, n_halted;
    int         alu_seen, regdst_seen, memorreg_seen, exc_seen;
    int         force_zero;
    logic [5:0] cur_op, cur_fn;
    logic [1:0] cur_exc;

    // ---------------- reference model ----------------
    function automatic bit is_shift(logic [5:0] f);
        return (f == 6'h00) || (f == 6'h02) || (f == 6'h03);
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        return op inside {C_OP_R, C_OP_ORI, C_OP_LW, C_OP_SW, C_OP_BEQ, C_OP_J};
    endfunction

    // What the sequencer must present during one cycle of a given phase.
    function automatic out_t model(step_t s);
        out_t o = '0;
        case (s.ph)
            P_FETCH:  begin o.mem_req = 1; o.ALUSrcB = 2'b01; o.ALUControl = 11'h021;
                            if (s.rdy) begin o.IRWrite = 1; o.PCEn = 1; end end
            P_DECODE: begin o.ALUSrcB = 2'b11; o.ALUControl = 11'h021; o.TargetWr = 1; end
            P_EXEC_R: begin o.ALUSrcA = is_shift(s.fn) ? 2'b10 : 2'b01;
                            o.ALUControl = {5'b0, s.fn}; o.TargetWr = 1; end
            P_EXEC_I: begin o.ALUSrcA = 2'b01; o.ALUSrcB = 2'b10; o.ALUControl = 11'h025;
                            o.TargetWr = 1; end
            P_WB_R:   begin o.RegWrite = 1; o.RegDst = (s.op == C_OP_R); o.retire = 1; end
            P_ADDR:   begin o.ALUSrcA = 2'b01; o.ALUSrcB = 2'b10; o.ALUControl = 11'h021;
                            o.TargetWr = 1; end
            P_MEM_RD: begin o.mem_req = 1; o.IorD = 1; end
            P_MEM_WR: begin o.mem_req = 1; o.mem_we = 1; o.IorD = 1; o.retire = s.rdy; end
            P_WB_MEM: begin o.RegWrite = 1; o.MemOrReg = 1; o.retire = 1; end
            P_BRANCH: begin o.ALUSrcA = 2'b01; o.ALUControl = 11'h023; o.PCSrc = 2'b01;
                            o.PCEn = s.zero; o.retire = 1; end
            P_JUMP:   begin o.PCSrc = 2'b10; o.PCEn = 1; o.retire = 1; end
            P_ILLEGAL: o.retire = 1;
            P_HALT:   begin o.halted = 1; o.exc_code = s.exc; end
            default:  ;
        endcase
        return o;
    endfunction

    function automatic void push(int ph, bit rdy);
        step_t s;
        s.ph   = ph;
        s.rdy  = rdy;
        s.zero = (force_zero < 0) ? bit'($urandom_range(0, 1)) : (force_zero != 0);
        s.op   = cur_op;
        s.fn   = cur_fn;
        s.exc  = cur_exc;
        seq.push_back(s);
    endfunction

    function automatic void push_any(int ph);
        push(ph, bit'($urandom_range(0, 1)));   // mem_ready is don't-care here
    endfunction

    function automatic void halt_tail(logic [1:0] exc);
        cur_exc = exc;
        for (int i = 0; i < 3; i++) push_any(P_HALT);
        push_any(P_RESET);
    endfunction

    // A memory phase: 'waits' not-ready cycles then ready; past WMAX it times out.
    function automatic bit push_mem(int ph, int waits);
        int n = (waits > WMAX) ? WMAX + 1 : waits;
        for (int i = 0; i < n; i++) push(ph, 1'b0);
        if (waits > WMAX) return 1'b1;
        push(ph, 1'b1);
        return 1'b0;
    endfunction

    function automatic void build(logic [5:0] op, logic [5:0] fn, int wf, int wm);
        cur_op = op; cur_fn = fn;
        if (push_mem(P_FETCH, wf)) begin halt_tail(2'b01); return; end
        push_any(P_DECODE);
        case (op)
            C_OP_R:   begin push_any(P_EXEC_R); push_any(P_WB_R); end
            C_OP_ORI: begin push_any(P_EXEC_I); push_any(P_WB_R); end
            C_OP_LW:  begin push_any(P_ADDR);
                            if (push_mem(P_MEM_RD, wm)) halt_tail(2'b01);
                            else push_any(P_WB_MEM); end
            C_OP_SW:  begin push_any(P_ADDR);
                            if (push_mem(P_MEM_WR, wm)) halt_tail(2'b01); end
            C_OP_BEQ: push_any(P_BRANCH);
            C_OP_J:   push_any(P_JUMP);
            default: begin
`ifdef ILLEGAL_TRAP_EN
                halt_tail(2'b10);
`else
                push_any(P_ILLEGAL);
`endif
            end
        endcase
    endfunction

    // ---------------- stimulus driver ----------------
    task automatic run_seq();
        step_t s;
        while (seq.size() > 0) begin
            s = seq.pop_front();
            @(negedge CLK); #1;
            reset     = (s.ph == P_RESET);
            Op        = s.op;
            Funct     = s.fn;
            Zero      = s.zero;
            mem_ready = s.rdy;
            exp_o     = model(s);
            exp_ph    = s.ph;
            chk_pend  = 1'b1;
        end
        #2;   // let the compare process see the last cycle
    endtask

    task automatic clr();
        n_cyc = 0; n_retire = 0; n_memreq = 0; n_memreq_iord = 0; n_pcen = 0; n_halted = 0;
        alu_seen = -1; regdst_seen = -1; memorreg_seen = -1; exc_seen = -1;
    endtask

    task automatic check(string name, int a, int e);
        n_tests++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, a, a, e, e);
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge CLK); #2;
            if (chk_pend) begin
                chk_pend = 1'b0;
                n_tests++;
                if (act !== exp_o) begin
                    n_fail++;
                    $display("FAIL cycle phase=%0d t=%0t: got %h, expected %h", exp_ph, $time, act, exp_o);
                end
                n_cyc++;
                if (retire)          n_retire++;
                if (mem_req)         n_memreq++;
                if (mem_req && IorD) n_memreq_iord++;
                if (PCEn)            n_pcen++;
                if (halted)   begin n_halted++; exc_seen = int'(exc_code); end
                if (RegWrite) begin regdst_seen = int'(RegDst); memorreg_seen = int'(MemOrReg); end
                if (TargetWr && ALUSrcB == 2'b00) alu_seen = int'(ALUControl);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [5:0] op, fn;
        int         k;
        reset = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; mem_ready = 1'b0;
        chk_pend = 1'b0; n_tests = 0; n_fail = 0; force_zero = -1;
        cur_op = '0; cur_fn = '0; cur_exc = 2'b00;

        clr(); push_any(P_RESET); push_any(P_RESET); run_seq();
        check("reset_outputs_quiet", n_memreq + n_retire + n_halted, 0);

        clr(); build(C_OP_R, 6'h20, 0, 0); run_seq();
        check("add_cycles", n_cyc, 4);
        check("add_retire", n_retire, 1);
        check("add_aluctl", alu_seen, 'h020);
        check("add_regdst", regdst_seen, 1);

        clr(); build(C_OP_ORI, 6'h15, 0, 0); run_seq();
        check("ori_cycles", n_cyc, 4);
        check("ori_regdst", regdst_seen, 0);

        clr(); build(C_OP_LW, 6'h00, 0, 3); run_seq();
        check("lw_cycles", n_cyc, 8);
        check("lw_data_req", n_memreq_iord, 4);
        check("lw_memorreg", memorreg_seen, 1);
        check("lw_retire", n_retire, 1);

        clr(); build(C_OP_SW, 6'h00, 0, 0); run_seq();
        check("sw_cycles", n_cyc, 4);
        check("sw_retire", n_retire, 1);

        force_zero = 1; clr(); build(C_OP_BEQ, 6'h00, 0, 0); run_seq();
        check("beq_taken_cycles", n_cyc, 3);
        check("beq_taken_pcen", n_pcen, 2);
        force_zero = 0; clr(); build(C_OP_BEQ, 6'h00, 0, 0); run_seq();
        check("beq_not_taken_cycles", n_cyc, 3);
        check("beq_not_taken_pcen", n_pcen, 1);
        force_zero = -1;

        clr(); build(C_OP_J, 6'h00, 0, 0); run_seq();
        check("j_cycles", n_cyc, 3);

        // exactly WMAX wait cycles is still tolerated
        clr(); build(C_OP_R, 6'h22, WMAX, 0); run_seq();
        check("max_wait_cycles", n_cyc, 4 + WMAX);
        check("max_wait_no_halt", n_halted, 0);

        clr(); build(C_OP_R, 6'h20, WMAX + 1, 0); run_seq();
        check("fetch_timeout_req_cycles", n_memreq, WMAX + 1);
        check("fetch_timeout_halted", n_halted, 3);
        check("fetch_timeout_exc", exc_seen, 1);

        clr(); build(C_OP_LW, 6'h00, 0, WMAX + 7); run_seq();
        check("memrd_timeout_exc", exc_seen, 1);
        check("memrd_timeout_retire", n_retire, 0);

        clr(); build(6'h3F, 6'h00, 0, 0); run_seq();
`ifdef ILLEGAL_TRAP_EN
        check("illegal_trap_exc", exc_seen, 2);
        check("illegal_trap_retire", n_retire, 0);
`else
        check("illegal_nop_cycles", n_cyc, 3);
        check("illegal_nop_retire", n_retire, 1);
        check("illegal_nop_regwrite", regdst_seen, -1);
`endif

        // reset while a store is waiting: outputs must drop in the reset cycle
        clr(); cur_op = C_OP_SW; cur_fn = 6'h00;
        push(P_FETCH, 1'b1); push_any(P_DECODE); push_any(P_ADDR);
        push(P_MEM_WR, 1'b0); push(P_MEM_WR, 1'b0); push_any(P_RESET); push(P_FETCH, 1'b0);
        run_seq();
        check("reset_mid_store_retire", n_retire, 0);
        // finish the fetch left pending after that reset
        clr(); cur_op = C_OP_J; push(P_FETCH, 1'b1); push_any(P_DECODE); push_any(P_JUMP); run_seq();
        check("after_reset_retire", n_retire, 1);

        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 6);
            fn = 6'($urandom_range(0, 63));
            case (k)
                0: begin op = C_OP_R; if ($urandom_range(0, 1) == 1) fn = 6'($urandom_range(0, 3)); end
                1: op = C_OP_ORI;
                2: op = C_OP_LW;
                3: op = C_OP_SW;
                4: op = C_OP_BEQ;
                5: op = C_OP_J;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (is_legal(op)) op = 6'($urandom_range(0, 63));
                end
            endcase
            build(op, fn,
                  ($urandom_range(0, 19) == 0) ? WMAX + 1 : $urandom_range(0, WMAX),
                  ($urandom_range(0, 19) == 0) ? WMAX + 1 : $urandom_range(0, WMAX));
            run_seq();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
